// File: rtl/snake_pkg.sv
// Shared snake-game definitions: one-hot direction encoding, default grid size, direction helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   DIR_*            5-bit one-hot direction codes shared by direction_logic and its consumers
//   DEFAULT_GRID_W/H default playfield size in cells
//   DEFAULT_COORD_W  default coordinate width (2^W must cover the larger grid dimension)
//   dir_reverse()    180-degree opposite of a move direction (NONE for anything else)
//   dir_is_move()    true only for exactly one of UP/DOWN/LEFT/RIGHT
package snake_pkg;

  localparam logic [4:0] DIR_NONE  = 5'b00001;
  localparam logic [4:0] DIR_UP    = 5'b00010;
  localparam logic [4:0] DIR_DOWN  = 5'b00100;
  localparam logic [4:0] DIR_LEFT  = 5'b01000;
  localparam logic [4:0] DIR_RIGHT = 5'b10000;

  localparam int DEFAULT_GRID_W  = 40;
  localparam int DEFAULT_GRID_H  = 30;
  localparam int DEFAULT_COORD_W = 6;

  function automatic logic [4:0] dir_reverse(input logic [4:0] d);
    logic [4:0] r;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = DIR_NONE;
    endcase
    return r;
  endfunction

  function automatic logic dir_is_move(input logic [4:0] d);
    logic m;
    case (d)
      DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT: m = 1'b1;
      default:                               m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/grid_coord_step.sv
// Next coordinate along one grid axis plus an out-of-bounds flag; one instance per axis.
// Latency: purely combinational.
// Backpressure: none.
//
// Parameters: LIMIT = number of cells on this axis (legal range 0..LIMIT-1), W = coordinate width.
// Ports:
//   coord - current coordinate
//   inc   - request +1 step on this axis
//   dec   - request -1 step on this axis (inc has priority; caller never sets both)
//   next  - coordinate after the step
//   oob   - the requested step crosses the grid edge
// Build option DIRECTION_STEPPER_WRAP_EN: an edge crossing wraps to the opposite edge;
// otherwise next holds the current coordinate when oob is set.
module grid_coord_step
  import snake_pkg::*;
#(
  parameter int LIMIT = DEFAULT_GRID_W,
  parameter int W     = DEFAULT_COORD_W
) (
  input  logic [W-1:0] coord,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] next,
  output logic         oob
);

  localparam logic [W-1:0] MAX_COORD = W'(LIMIT - 1);
  localparam logic [W-1:0] ONE       = W'(1);

  // Bounds come from the grid size, not the coordinate width, so a
  // non-power-of-two grid still stops (or wraps) at the real edge.
  logic at_low;
  logic at_high;

  assign at_low  = (coord == '0);
  assign at_high = (coord == MAX_COORD);

  always_comb begin
    next = coord;
    oob  = 1'b0;
    if (inc) begin
      if (at_high) begin
        oob = 1'b1;
`ifdef DIRECTION_STEPPER_WRAP_EN
        next = '0;
`else
        next = coord;
`endif
      end else begin
        next = coord + ONE;
      end
    end else if (dec) begin
      if (at_low) begin
        oob = 1'b1;
`ifdef DIRECTION_STEPPER_WRAP_EN
        next = MAX_COORD;
`else
        next = coord;
`endif
      end else begin
        next = coord - ONE;
      end
    end
  end

endmodule

// File: rtl/direction_stepper.sv
// Filters one-hot direction requests and advances the snake head one cell per game tick.
// Latency: tick sampled at edge N -> new head/heading/step visible after edge N (1 clock).
// Backpressure: none; every tick is acted on, back-to-back ticks give one step each.
//
// Ports:
//   in_clk       - clock, rising edge
//   in_rst_n     - asynchronous active-low reset
//   in_direction - one-hot request from direction_logic (NONE/zero/multi-hot/reversal ignored)
//   in_tick      - one-cycle game-rate strobe
//   out_head_x   - head x coordinate (reset START_X)
//   out_head_y   - head y coordinate (reset START_Y)
//   out_heading  - committed heading (reset DIR_NONE)
//   out_step     - one-cycle pulse after each edge on which the head moved
//   out_dead     - sticky wall-hit flag (constant 0 in the wrap build)
// Build option DIRECTION_STEPPER_WRAP_EN: head wraps at the grid edges, DEAD never reached.
module direction_stepper
  import snake_pkg::*;
#(
  parameter int GRID_W  = DEFAULT_GRID_W,
  parameter int GRID_H  = DEFAULT_GRID_H,
  parameter int COORD_W = DEFAULT_COORD_W,
  parameter int START_X = 20,
  parameter int START_Y = 15
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic [4:0]         in_direction,
  input  logic               in_tick,
  output logic [COORD_W-1:0] out_head_x,
  output logic [COORD_W-1:0] out_head_y,
  output logic [4:0]         out_heading,
  output logic               out_step,
  output logic               out_dead
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  localparam logic [COORD_W-1:0] RST_X = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] RST_Y = COORD_W'(START_Y);

  logic [1:0]         state;
  logic [4:0]         pending;
  logic [4:0]         heading;
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic               step;

  logic               req_valid;
  logic [4:0]         candidate;
  logic [4:0]         next_heading;
  logic               do_move;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               x_oob;
  logic               y_oob;

  // Reversal is judged against the committed heading, not pending, so a
  // LEFT-then-DOWN burst while heading UP keeps LEFT (DOWN is still a reversal).
  assign req_valid = dir_is_move(in_direction) &&
                     (in_direction != dir_reverse(heading));

  // A request in the same cycle as the tick takes effect on that tick.
  assign candidate    = req_valid ? in_direction : pending;
  assign next_heading = (candidate == DIR_NONE) ? heading : candidate;

  // IDLE waits for the first real direction; DEAD matches neither term.
  assign do_move = in_tick &&
                   ((state == ST_RUN) ||
                    ((state == ST_IDLE) && (candidate != DIR_NONE)));

  grid_coord_step #(
    .LIMIT (GRID_W),
    .W     (COORD_W)
  ) u_step_x (
    .coord (head_x),
    .inc   (next_heading == DIR_RIGHT),
    .dec   (next_heading == DIR_LEFT),
    .next  (next_x),
    .oob   (x_oob)
  );

  grid_coord_step #(
    .LIMIT (GRID_H),
    .W     (COORD_W)
  ) u_step_y (
    .coord (head_y),
    .inc   (next_heading == DIR_DOWN),
    .dec   (next_heading == DIR_UP),
    .next  (next_y),
    .oob   (y_oob)
  );

`ifdef DIRECTION_STEPPER_WRAP_EN

  // Edge crossings are legal here; the sub-modules already produce the wrapped value.
  wire unused_oob = x_oob ^ y_oob;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state   <= ST_IDLE;
      pending <= DIR_NONE;
      heading <= DIR_NONE;
      head_x  <= RST_X;
      head_y  <= RST_Y;
      step    <= 1'b0;
    end else begin
      if (req_valid) begin
        pending <= in_direction;
      end
      step <= 1'b0;
      if (do_move) begin
        heading <= next_heading;
        head_x  <= next_x;
        head_y  <= next_y;
        step    <= 1'b1;
        state   <= ST_RUN;
      end
    end
  end

  assign out_dead = 1'b0;

`else

  localparam logic [1:0] ST_DEAD = 2'd2;

  logic dead;
  logic wall;

  assign wall = x_oob | y_oob;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state   <= ST_IDLE;
      pending <= DIR_NONE;
      heading <= DIR_NONE;
      head_x  <= RST_X;
      head_y  <= RST_Y;
      step    <= 1'b0;
      dead    <= 1'b0;
    end else begin
      if (req_valid && (state != ST_DEAD)) begin
        pending <= in_direction;
      end
      step <= 1'b0;
      if (do_move) begin
        heading <= next_heading;
        if (wall) begin
          // Blocked step: head stays on the wall cell, no step pulse.
          dead  <= 1'b1;
          state <= ST_DEAD;
        end else begin
          head_x <= next_x;
          head_y <= next_y;
          step   <= 1'b1;
          state  <= ST_RUN;
        end
      end
    end
  end

  assign out_dead = dead;

`endif

  assign out_head_x  = head_x;
  assign out_head_y  = head_y;
  assign out_heading = heading;
  assign out_step    = step;

endmodule

// File: tb/tb_direction_stepper.sv
// Self-checking bench for direction_stepper: table of per-cycle vectors plus
// hand-written wall/wrap and asynchronous-reset sequences.
module tb_direction_stepper;

  localparam logic [4:0] D_NONE  = 5'b00001;
  localparam logic [4:0] D_UP    = 5'b00010;
  localparam logic [4:0] D_DOWN  = 5'b00100;
  localparam logic [4:0] D_LEFT  = 5'b01000;
  localparam logic [4:0] D_RIGHT = 5'b10000;

  logic       in_clk;
  logic       in_rst_n;
  logic [4:0] in_direction;
  logic       in_tick;
  logic [5:0] out_head_x;
  logic [5:0] out_head_y;
  logic [4:0] out_heading;
  logic       out_step;
  logic       out_dead;

  int checks   = 0;
  int failures = 0;

  direction_stepper dut (
    .in_clk       (in_clk),
    .in_rst_n     (in_rst_n),
    .in_direction (in_direction),
    .in_tick      (in_tick),
    .out_head_x   (out_head_x),
    .out_head_y   (out_head_y),
    .out_heading  (out_heading),
    .out_step     (out_step),
    .out_dead     (out_dead)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [4:0] dir;
    logic       tick;
    logic [5:0] x;
    logic [5:0] y;
    logic [4:0] hd;
    logic       step;
    logic       dead;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [5:0] x, input logic [5:0] y,
                           input logic [4:0] hd, input logic step, input logic dead);
    check({tag, ".x"},       32'(out_head_x),  32'(x));
    check({tag, ".y"},       32'(out_head_y),  32'(y));
    check({tag, ".heading"}, 32'(out_heading), 32'(hd));
    check({tag, ".step"},    32'(out_step),    32'(step));
    check({tag, ".dead"},    32'(out_dead),    32'(dead));
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit after the edge.
  task automatic cycle(input logic [4:0] dir, input logic tick);
    in_direction = dir;
    in_tick      = tick;
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    // dir, tick, x, y, heading, step, dead (state after the edge)
    vecs[0]  = '{D_NONE,  1'b1, 6'd20, 6'd15, D_NONE,  1'b0, 1'b0}; // idle ticks ignored
    vecs[1]  = '{D_NONE,  1'b1, 6'd20, 6'd15, D_NONE,  1'b0, 1'b0};
    vecs[2]  = '{D_NONE,  1'b1, 6'd20, 6'd15, D_NONE,  1'b0, 1'b0};
    vecs[3]  = '{D_RIGHT, 1'b0, 6'd20, 6'd15, D_NONE,  1'b0, 1'b0}; // latch RIGHT
    vecs[4]  = '{D_NONE,  1'b1, 6'd21, 6'd15, D_RIGHT, 1'b1, 1'b0}; // start
    vecs[5]  = '{D_NONE,  1'b0, 6'd21, 6'd15, D_RIGHT, 1'b0, 1'b0}; // pulse ends
    vecs[6]  = '{D_LEFT,  1'b0, 6'd21, 6'd15, D_RIGHT, 1'b0, 1'b0}; // reversal
    vecs[7]  = '{D_NONE,  1'b1, 6'd22, 6'd15, D_RIGHT, 1'b1, 1'b0};
    vecs[8]  = '{D_UP,    1'b0, 6'd22, 6'd15, D_RIGHT, 1'b0, 1'b0};
    vecs[9]  = '{D_NONE,  1'b1, 6'd22, 6'd14, D_UP,    1'b1, 1'b0};
    vecs[10] = '{D_LEFT,  1'b0, 6'd22, 6'd14, D_UP,    1'b0, 1'b0}; // latch order
    vecs[11] = '{D_DOWN,  1'b0, 6'd22, 6'd14, D_UP,    1'b0, 1'b0};
    vecs[12] = '{D_NONE,  1'b1, 6'd21, 6'd14, D_LEFT,  1'b1, 1'b0};
    vecs[13] = '{D_DOWN,  1'b1, 6'd21, 6'd15, D_DOWN,  1'b1, 1'b0}; // same-cycle
    vecs[14] = '{D_NONE,  1'b1, 6'd21, 6'd16, D_DOWN,  1'b1, 1'b0}; // back-to-back
    vecs[15] = '{5'b00110,1'b0, 6'd21, 6'd16, D_DOWN,  1'b0, 1'b0}; // multi-hot
    vecs[16] = '{5'b00000,1'b1, 6'd21, 6'd17, D_DOWN,  1'b1, 1'b0}; // zero
    vecs[17] = '{D_LEFT,  1'b1, 6'd20, 6'd17, D_LEFT,  1'b1, 1'b0};

    in_rst_n     = 1'b0;
    in_direction = D_NONE;
    in_tick      = 1'b0;
    repeat (3) @(posedge in_clk);
    #1;
    check_all("reset", 6'd20, 6'd15, D_NONE, 1'b0, 1'b0);
    in_rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].dir, vecs[i].tick);
      check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].hd,
                vecs[i].step, vecs[i].dead);
    end

    // Walk left to the wall at x=0.
    for (int i = 1; i <= 20; i++) begin
      cycle(D_NONE, 1'b1);
      check($sformatf("walk%0d.x", i), 32'(out_head_x), 32'(20 - i));
      check($sformatf("walk%0d.step", i), 32'(out_step), 32'd1);
    end

    // Step off the left edge.
    cycle(D_NONE, 1'b1);
`ifdef DIRECTION_STEPPER_WRAP_EN
    check_all("edge", 6'd39, 6'd17, D_LEFT, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cycle(D_NONE, 1'b1);
      check_all($sformatf("post_wrap%0d", i), 6'(39 - i), 6'd17, D_LEFT, 1'b1, 1'b0);
    end
`else
    check_all("edge", 6'd0, 6'd17, D_LEFT, 1'b0, 1'b1);
    // DEAD: ticks and a legal request change nothing.
    for (int i = 1; i <= 3; i++) begin
      cycle(D_UP, 1'b1);
      check_all($sformatf("dead%0d", i), 6'd0, 6'd17, D_LEFT, 1'b0, 1'b1);
    end
`endif

    // Asynchronous reset between edges, checked before the next edge.
    in_direction = D_NONE;
    in_tick      = 1'b0;
    #2;
    in_rst_n = 1'b0;
    #1;
    check_all("async_rst", 6'd20, 6'd15, D_NONE, 1'b0, 1'b0);
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;

    // pending cleared by reset: ticks without a request stay idle.
    cycle(D_NONE, 1'b1);
    check_all("post_rst_idle0", 6'd20, 6'd15, D_NONE, 1'b0, 1'b0);
    cycle(D_NONE, 1'b1);
    check_all("post_rst_idle1", 6'd20, 6'd15, D_NONE, 1'b0, 1'b0);
    cycle(D_DOWN, 1'b1);
    check_all("post_rst_start", 6'd20, 6'd16, D_DOWN, 1'b1, 1'b0);
    cycle(D_NONE, 1'b0);
    check_all("post_rst_quiet", 6'd20, 6'd16, D_DOWN, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
